// File: rtl/id_ex_hazard_latch_pkg.sv
// ============================================================================
// id_ex_hazard_latch_pkg : shared pipeline types and encodings for ID/EX.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

package id_ex_hazard_latch_pkg;

    localparam int NB_DATA  = 32;
    localparam int NB_REG   = 5;
    localparam int NB_ALUOP = 4;
    localparam int NB_CNT   = 16;

    typedef enum logic [1:0] {
        REGDST_RT  = 2'b00,
        REGDST_RD  = 2'b01,
        REGDST_R31 = 2'b10
    } regdst_e;

    typedef enum logic [NB_ALUOP-1:0] {
        ALU_ADD  = 4'h0,
        ALU_SUB  = 4'h1,
        ALU_AND  = 4'h2,
        ALU_OR   = 4'h3,
        ALU_XOR  = 4'h4,
        ALU_NOR  = 4'h5,
        ALU_SLT  = 4'h6,
        ALU_SLL  = 4'h7,
        ALU_SRL  = 4'h8,
        ALU_SRA  = 4'h9,
        ALU_LUI  = 4'hA
    } aluop_e;

    typedef struct packed {
        logic                reg_write;
        logic                mem_read;
        logic                mem_write;
        logic                mem_to_reg;
        logic                alu_src;
        logic [1:0]          reg_dst;
        logic [NB_ALUOP-1:0] alu_op;
    } ctrl_t;

    localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

`default_nettype wire

// File: rtl/id_ex_hazard_latch_if.sv
// ============================================================================
// id_ex_hazard_latch_if : ID-side inputs and EX-side outputs of the ID/EX latch.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

interface id_ex_hazard_latch_if #(
    parameter int NB_DATA = 32,
    parameter int NB_REG  = 5,
    parameter int NB_CNT  = 16
);
    import id_ex_hazard_latch_pkg::*;

    logic               enable;
    logic               flush;
    logic               cnt_clear;

    logic               id_valid;
    logic [NB_REG-1:0]  id_rs;
    logic [NB_REG-1:0]  id_rt;
    logic [NB_REG-1:0]  id_rd;
    logic               id_uses_rs;
    logic               id_uses_rt;
    logic [NB_DATA-1:0] id_data_a;
    logic [NB_DATA-1:0] id_data_b;
    logic [NB_DATA-1:0] id_imm;
    ctrl_t              id_ctrl;

    logic               ex_valid;
    logic [NB_REG-1:0]  ex_rs;
    logic [NB_REG-1:0]  ex_rt;
    logic [NB_REG-1:0]  ex_rd;
    logic [NB_DATA-1:0] ex_data_a;
    logic [NB_DATA-1:0] ex_data_b;
    logic [NB_DATA-1:0] ex_imm;
    ctrl_t              ex_ctrl;

    logic               stall;
    logic [NB_CNT-1:0]  stall_cnt;

    modport master (
        output enable, flush, cnt_clear,
        output id_valid, id_rs, id_rt, id_rd, id_uses_rs, id_uses_rt,
        output id_data_a, id_data_b, id_imm, id_ctrl,
        input  ex_valid, ex_rs, ex_rt, ex_rd, ex_data_a, ex_data_b, ex_imm, ex_ctrl,
        input  stall, stall_cnt
    );

    modport slave (
        input  enable, flush, cnt_clear,
        input  id_valid, id_rs, id_rt, id_rd, id_uses_rs, id_uses_rt,
        input  id_data_a, id_data_b, id_imm, id_ctrl,
        output ex_valid, ex_rs, ex_rt, ex_rd, ex_data_a, ex_data_b, ex_imm, ex_ctrl,
        output stall, stall_cnt
    );

endinterface

`default_nettype wire

// File: rtl/id_ex_hazard_latch_load_use_detector.sv
// ============================================================================
// id_ex_hazard_latch_load_use_detector : combinational load-use stall request.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module id_ex_hazard_latch_load_use_detector #(
    parameter int NB_REG = 5
) (
    input  logic              enable,
    input  logic              flush,
    input  logic              ex_valid,
    input  logic              ex_mem_read,
    input  logic [NB_REG-1:0] ex_rt,
    input  logic [NB_REG-1:0] id_rs,
    input  logic [NB_REG-1:0] id_rt,
    input  logic              id_uses_rs,
    input  logic              id_uses_rt,
    output logic              stall
);

    logic rs_hit;
    logic rt_hit;

    assign rs_hit = id_uses_rs & (ex_rt == id_rs);
    assign rt_hit = id_uses_rt & (ex_rt == id_rt);

    // $0 is hardwired, so a load targeting it never produces a dependency
    assign stall = enable & ~flush & ex_valid & ex_mem_read
                 & (ex_rt != '0) & (rs_hit | rt_hit);

endmodule

`default_nettype wire

// File: rtl/id_ex_hazard_latch.sv
// ============================================================================
// id_ex_hazard_latch : ID/EX pipeline register with load-use bubble insertion
//                      and a saturating stall counter for the debug unit.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module id_ex_hazard_latch #(
    parameter int NB_DATA = 32,
    parameter int NB_REG  = 5,
    parameter int NB_CNT  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    id_ex_hazard_latch_if.slave   bus
);
    import id_ex_hazard_latch_pkg::*;

    logic               stall;
    logic               bubble;

    logic               ex_valid_q;
    logic [NB_REG-1:0]  ex_rs_q;
    logic [NB_REG-1:0]  ex_rt_q;
    logic [NB_REG-1:0]  ex_rd_q;
    logic [NB_DATA-1:0] ex_data_a_q;
    logic [NB_DATA-1:0] ex_data_b_q;
    logic [NB_DATA-1:0] ex_imm_q;
    ctrl_t              ex_ctrl_q;
    logic [NB_CNT-1:0]  stall_cnt_q;

    id_ex_hazard_latch_load_use_detector #(
        .NB_REG (NB_REG)
    ) u_detect (
        .enable      (bus.enable),
        .flush       (bus.flush),
        .ex_valid    (ex_valid_q),
        .ex_mem_read (ex_ctrl_q.mem_read),
        .ex_rt       (ex_rt_q),
        .id_rs       (bus.id_rs),
        .id_rt       (bus.id_rt),
        .id_uses_rs  (bus.id_uses_rs),
        .id_uses_rt  (bus.id_uses_rt),
        .stall       (stall)
    );

    // Flush and stall produce the identical bubble; only stall is counted
    assign bubble = bus.flush | stall;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_valid_q  <= 1'b0;
            ex_rs_q     <= '0;
            ex_rt_q     <= '0;
            ex_rd_q     <= '0;
            ex_data_a_q <= '0;
            ex_data_b_q <= '0;
            ex_imm_q    <= '0;
            ex_ctrl_q   <= CTRL_BUBBLE;
        end else if (bus.enable) begin
            if (bubble) begin
                ex_valid_q  <= 1'b0;
                ex_rs_q     <= '0;
                ex_rt_q     <= '0;
                ex_rd_q     <= '0;
                ex_data_a_q <= '0;
                ex_data_b_q <= '0;
                ex_imm_q    <= '0;
                ex_ctrl_q   <= CTRL_BUBBLE;
            end else begin
                ex_valid_q  <= bus.id_valid;
                ex_rs_q     <= bus.id_rs;
                ex_rt_q     <= bus.id_rt;
                ex_rd_q     <= bus.id_rd;
                ex_data_a_q <= bus.id_data_a;
                ex_data_b_q <= bus.id_data_b;
                ex_imm_q    <= bus.id_imm;
                ex_ctrl_q   <= bus.id_ctrl;
            end
        end
    end

    // Clear is honoured even while frozen and beats a same-edge increment
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else if (bus.cnt_clear) begin
            stall_cnt_q <= '0;
        end else if (bus.enable && stall && (stall_cnt_q != '1)) begin
            stall_cnt_q <= stall_cnt_q + NB_CNT'(1);
        end
    end

    assign bus.ex_valid  = ex_valid_q;
    assign bus.ex_rs     = ex_rs_q;
    assign bus.ex_rt     = ex_rt_q;
    assign bus.ex_rd     = ex_rd_q;
    assign bus.ex_data_a = ex_data_a_q;
    assign bus.ex_data_b = ex_data_b_q;
    assign bus.ex_imm    = ex_imm_q;
    assign bus.ex_ctrl   = ex_ctrl_q;
    assign bus.stall     = stall;
    assign bus.stall_cnt = stall_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_id_ex_hazard_latch.sv
// ============================================================================
// tb_id_ex_hazard_latch : directed stimulus with a queue-based scoreboard.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module tb_id_ex_hazard_latch;
    import id_ex_hazard_latch_pkg::*;

    localparam int TB_NB_CNT = 2;
    localparam int OBS_W     = 1 + 3*5 + 3*32 + $bits(ctrl_t);

    typedef logic [OBS_W-1:0] obs_t;

    typedef struct packed {
        logic        valid;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic        uses_rs;
        logic        uses_rt;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] imm;
        ctrl_t       ctrl;
    } instr_t;

    typedef struct {
        obs_t ex;
        bit   stall;
        int   cnt;
        int   step;
    } exp_t;

    logic clk;
    logic rst;
    exp_t exp_q[$];
    int   checks;
    int   passes;
    int   step;

    instr_t nop_i, add123, lw5, add_r5, add_rt5, lw0, read0, nouse5, lw5b, add_r7;

    id_ex_hazard_latch_if #(.NB_DATA(32), .NB_REG(5), .NB_CNT(TB_NB_CNT)) bus ();

    id_ex_hazard_latch #(.NB_DATA(32), .NB_REG(5), .NB_CNT(TB_NB_CNT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic instr_t mk(input bit v, input int rs, input int rt, input int rd,
                                  input bit urs, input bit urt, input int a, input int b,
                                  input int imm, input bit rw, input bit mr, input bit mw,
                                  input bit m2r, input bit asrc, input int rdst, input int aop);
        instr_t i;
        i.valid          = v;
        i.rs             = 5'(rs);
        i.rt             = 5'(rt);
        i.rd             = 5'(rd);
        i.uses_rs        = urs;
        i.uses_rt        = urt;
        i.a              = 32'(a);
        i.b              = 32'(b);
        i.imm            = 32'(imm);
        i.ctrl.reg_write = rw;
        i.ctrl.mem_read  = mr;
        i.ctrl.mem_write = mw;
        i.ctrl.mem_to_reg= m2r;
        i.ctrl.alu_src   = asrc;
        i.ctrl.reg_dst   = 2'(rdst);
        i.ctrl.alu_op    = 4'(aop);
        return i;
    endfunction

    function automatic obs_t obs(input instr_t i);
        return {i.valid, i.rs, i.rt, i.rd, i.a, i.b, i.imm, i.ctrl};
    endfunction

    task automatic drive(input instr_t i, input bit fl, input bit en, input bit clr);
        bus.id_valid   = i.valid;
        bus.id_rs      = i.rs;
        bus.id_rt      = i.rt;
        bus.id_rd      = i.rd;
        bus.id_uses_rs = i.uses_rs;
        bus.id_uses_rt = i.uses_rt;
        bus.id_data_a  = i.a;
        bus.id_data_b  = i.b;
        bus.id_imm     = i.imm;
        bus.id_ctrl    = i.ctrl;
        bus.flush      = fl;
        bus.enable     = en;
        bus.cnt_clear  = clr;
    endtask

    task automatic push(input instr_t ex_exp, input bit stall_exp, input int cnt_exp);
        exp_t e;
        step    = step + 1;
        e.ex    = obs(ex_exp);
        e.stall = stall_exp;
        e.cnt   = cnt_exp;
        e.step  = step;
        exp_q.push_back(e);
    endtask

    // One cycle: ID presents id; the following negedge must show ex_exp in EX
    task automatic cyc(input instr_t id, input bit fl, input bit en, input bit clr,
                       input instr_t ex_exp, input bit stall_exp, input int cnt_exp);
        drive(id, fl, en, clr);
        push(ex_exp, stall_exp, cnt_exp);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            obs_t got;
            e   = exp_q.pop_front();
            got = {bus.ex_valid, bus.ex_rs, bus.ex_rt, bus.ex_rd,
                   bus.ex_data_a, bus.ex_data_b, bus.ex_imm, bus.ex_ctrl};
            checks = checks + 1;
            if (got === e.ex) passes = passes + 1;
            else $display("FAIL step%0d ex_regs: got %h expected %h", e.step, got, e.ex);
            checks = checks + 1;
            if (bus.stall === e.stall) passes = passes + 1;
            else $display("FAIL step%0d stall: got %b expected %b", e.step, bus.stall, e.stall);
            checks = checks + 1;
            if (bus.stall_cnt === TB_NB_CNT'(e.cnt)) passes = passes + 1;
            else $display("FAIL step%0d stall_cnt: got %0d expected %0d", e.step, bus.stall_cnt, e.cnt);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        checks = 0;
        passes = 0;
        step   = 0;
        //            v  rs rt rd urs urt  a    b    imm rw mr mw m2r as rdst aop
        nop_i   = mk(0, 0, 0, 0, 0, 0, 0,   0,   0,  0, 0, 0, 0, 0, 0, 0);
        add123  = mk(1, 1, 2, 3, 1, 1, 11,  22,  0,  1, 0, 0, 0, 0, 1, ALU_ADD);
        lw5     = mk(1, 1, 5, 0, 1, 0, 100, 0,   4,  1, 1, 0, 1, 1, 0, ALU_ADD);
        add_r5  = mk(1, 5, 2, 6, 1, 1, 55,  22,  0,  1, 0, 0, 0, 0, 1, ALU_ADD);
        add_rt5 = mk(1, 2, 5, 9, 1, 1, 22,  55,  0,  1, 0, 0, 0, 0, 1, ALU_SUB);
        lw0     = mk(1, 1, 0, 0, 1, 0, 100, 0,   8,  1, 1, 0, 1, 1, 0, ALU_ADD);
        read0   = mk(1, 0, 0, 4, 1, 1, 0,   0,   0,  1, 0, 0, 0, 0, 1, ALU_OR);
        nouse5  = mk(1, 5, 0, 0, 0, 0, 0,   0,   32'h1234, 1, 0, 0, 0, 1, 0, ALU_LUI);
        lw5b    = mk(1, 5, 7, 0, 1, 0, 77,  0,   12, 1, 1, 0, 1, 1, 0, ALU_ADD);
        add_r7  = mk(1, 7, 3, 8, 1, 1, 70,  33,  0,  1, 0, 0, 0, 0, 1, ALU_AND);

        rst = 1'b1;
        drive(nop_i, 0, 1, 0);
        @(posedge clk);
        #1;
        cyc(nop_i,   0, 1, 0, nop_i,   0, 0);   // reset state
        rst = 1'b0;

        cyc(add123,  0, 1, 0, nop_i,   0, 0);   // pass-through
        cyc(lw5,     0, 1, 0, add123,  0, 0);
        cyc(add_r5,  0, 1, 0, lw5,     1, 0);   // load-use via rs
        cyc(add_r5,  0, 1, 0, nop_i,   0, 1);   // bubble
        cyc(lw0,     0, 1, 0, add_r5,  0, 1);
        cyc(read0,   0, 1, 0, lw0,     0, 1);   // $0 never stalls
        cyc(lw5,     0, 1, 0, read0,   0, 1);
        cyc(nouse5,  0, 1, 0, lw5,     0, 1);   // rs=5 but unused
        cyc(lw5,     0, 1, 0, nouse5,  0, 1);
        cyc(add_r5,  1, 1, 0, lw5,     0, 1);   // flush beats stall
        cyc(lw5,     0, 1, 0, nop_i,   0, 1);
        for (int k = 0; k < 3; k++)
            cyc(add_r5, 0, 0, 0, lw5,  0, 1);   // frozen
        cyc(add_r5,  0, 1, 0, lw5,     1, 1);
        cyc(add_r5,  0, 1, 0, nop_i,   0, 2);
        cyc(lw5,     0, 1, 0, add_r5,  0, 2);   // load then dependent load
        cyc(lw5b,    0, 1, 0, lw5,     1, 2);
        cyc(lw5b,    0, 1, 0, nop_i,   0, 3);
        cyc(add_r7,  0, 1, 0, lw5b,    1, 3);
        cyc(add_r7,  0, 1, 0, nop_i,   0, 3);   // saturated
        cyc(lw5,     0, 1, 0, add_r7,  0, 3);
        cyc(add_rt5, 0, 1, 0, lw5,     1, 3);   // load-use via rt
        cyc(add_rt5, 0, 1, 0, nop_i,   0, 3);
        cyc(lw5,     0, 1, 0, add_rt5, 0, 3);
        cyc(add_r5,  0, 1, 1, lw5,     1, 3);   // clear wins over increment
        cyc(add_r5,  0, 1, 0, nop_i,   0, 0);
        cyc(lw5,     0, 1, 0, add_r5,  0, 0);
        cyc(add_r5,  0, 1, 0, lw5,     1, 0);
        cyc(add_r5,  0, 0, 1, nop_i,   0, 1);   // clear while frozen
        cyc(add_r5,  0, 1, 0, nop_i,   0, 0);
        cyc(lw5,     0, 1, 0, add_r5,  0, 0);
        cyc(add_r5,  0, 1, 0, lw5,     1, 0);
        cyc(add_r5,  0, 1, 0, nop_i,   0, 1);
        cyc(lw5,     0, 1, 0, add_r5,  0, 1);

        // asynchronous reset in the middle of a stall cycle
        drive(add_r5, 0, 1, 0);
        #1;
        rst = 1'b1;
        push(nop_i, 0, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc(add_r5,  0, 1, 0, nop_i,   0, 0);
        cyc(nop_i,   0, 1, 0, add_r5,  0, 0);

        repeat (2) @(posedge clk);
        #1;
        checks = checks + 1;
        if (exp_q.size() == 0) passes = passes + 1;
        else $display("FAIL drain: got %0d pending expected 0", exp_q.size());

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

`default_nettype wire
